// File: rtl/async_to_sync_rx_if.sv
// rtl/async_to_sync_rx_if.sv - 4-phase bundled-data input and valid/ready output bundle
interface async_to_sync_rx_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic              req_i;
  logic [DATA_W-1:0] data_i;
  logic              ack_o;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] data_o;
  logic [LVL_W-1:0]  level_o;

  // Producer/consumer side: drives the async request, bundled data and stream ready
  modport master (
    output req_i, data_i, ready_i,
    input  ack_o, valid_o, data_o, level_o
  );

  // Receiver side
  modport slave (
    input  req_i, data_i, ready_i,
    output ack_o, valid_o, data_o, level_o
  );
endinterface

// File: rtl/async_to_sync_rx.sv
// rtl/async_to_sync_rx.sv - 4-phase bundled-data receiver with req synchronizer and token FIFO
module async_to_sync_rx #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  async_to_sync_rx_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RTZ = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic [DATA_W-1:0]      mem_q [DEPTH];
  logic [DATA_W-1:0]      mem_d [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;

  logic req_s;
  logic full;
  logic push;
  logic pop;

  assign req_s = sync_q[SYNC_STAGES-1];
  assign full  = (level_q == LVL_W'(DEPTH));
  // Full is judged on the current level only, so a same-cycle pop never frees room for a push
  assign push  = (state_q == IDLE) && req_s && !full;
  assign pop   = (level_q != '0) && bus.ready_i;

  assign bus.ack_o   = ack_q;
  assign bus.valid_o = (level_q != '0);
  assign bus.data_o  = mem_q[rd_ptr_q];
  assign bus.level_o = level_q;

  // Next-state: synchronizer shift, handshake FSM, FIFO storage/pointers/level
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], bus.req_i};
    state_d  = state_q;
    ack_d    = ack_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    case (state_q)
      IDLE: begin
        if (push) begin
          state_d = WAIT_RTZ;
          ack_d   = 1'b1;
        end
      end
      WAIT_RTZ: begin
        if (!req_s) begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = bus.data_i;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers; reset clears everything, including stored tokens, without waiting for a clock
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: tb/tb_async_to_sync_rx.sv
// tb/tb_async_to_sync_rx.sv - self-checking bench for async_to_sync_rx
module tb_async_to_sync_rx;
  logic clk = 1'b0;
  logic rst_n;

  async_to_sync_rx_if #(.DATA_W(32), .DEPTH(2)) bus ();

  async_to_sync_rx #(.DATA_W(32), .DEPTH(2), .SYNC_STAGES(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] data;
    logic        ready;
    logic        ack;
    logic        valid;
    logic [31:0] dout;
    logic [1:0]  level;
  } vec_t;

  vec_t        vt [7];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic        sb_en = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] cur_data = '0;
  int          n_ack = 0;
  int          n_rx = 0;
  int          ready_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock edge; outputs sampled at the following falling edge.
  // With sb_en the queue model follows captures (ack rise) and pops (valid && ready).
  task automatic step();
    logic        pop_now;
    logic [31:0] pop_data;
    pop_now  = bus.valid_o && bus.ready_i;
    pop_data = bus.data_o;
    @(posedge clk);
    @(negedge clk);
    if (sb_en) begin
      if (pop_now) begin
        if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
        else begin
          chk("pop_data", pop_data, exp_q.pop_front());
          n_rx++;
        end
      end
      if (bus.ack_o && !prev_ack) begin
        exp_q.push_back(cur_data);
        n_ack++;
      end
      chk("level_model", bus.level_o, exp_q.size());
      chk("level_max", bus.level_o <= 2'd2, 1);
    end
    prev_ack = bus.ack_o;
    if (ready_mode == 1) bus.ready_i = ~bus.ready_i;
    else if (ready_mode == 2) bus.ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ack(input logic val, input int bound, input string name);
    int n = 0;
    while (bus.ack_o !== val && n < bound) begin
      step();
      n++;
    end
    chk(name, bus.ack_o, val);
  endtask

  task automatic send_token(input logic [31:0] d);
    bus.data_i = d;
    cur_data   = d;
    bus.req_i  = 1'b1;
    wait_ack(1'b1, 200, "tok_ack_rise");
    bus.req_i = 1'b0;
    wait_ack(1'b0, 20, "tok_ack_fall");
  endtask

  task automatic drain();
    int n = 0;
    ready_mode  = 0;
    bus.ready_i = 1'b1;
    while ((bus.valid_o || exp_q.size() != 0) && n < 20) begin
      step();
      n++;
    end
    chk("drain_empty", bus.level_o, 0);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.req_i   = 1'b0;
    bus.data_i  = '0;
    bus.ready_i = 1'b0;
    ready_mode  = 0;
    sb_en       = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    prev_ack = 1'b0;
    n_ack    = 0;
    n_rx     = 0;
  endtask

  initial begin
    logic seen;

    vt[0] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0,        2'd0};
    vt[1] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0,        2'd0};
    vt[2] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 2'd1};
    vt[3] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0,        2'd0};
    vt[4] = '{1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0,        2'd0};
    vt[5] = '{1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0,        2'd0};
    vt[6] = '{1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0,        2'd0};

    // Reset state
    rst_n       = 1'b0;
    bus.req_i   = 1'b1;
    bus.data_i  = 32'h12345678;
    bus.ready_i = 1'b1;
    #12;
    chk("rst_ack", bus.ack_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_level", bus.level_o, 0);
    chk("rst_data", bus.data_o, 0);

    // Single token, table driven
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus.req_i   = vt[i].req;
      bus.data_i  = vt[i].data;
      bus.ready_i = vt[i].ready;
      step();
      chk($sformatf("vec%0d_ack", i), bus.ack_o, vt[i].ack);
      chk($sformatf("vec%0d_valid", i), bus.valid_o, vt[i].valid);
      chk($sformatf("vec%0d_level", i), bus.level_o, vt[i].level);
      if (vt[i].valid) chk($sformatf("vec%0d_data", i), bus.data_o, vt[i].dout);
    end

    // Fill and backpressure
    do_reset();
    send_token(32'h1);
    send_token(32'h2);
    chk("fill_level", bus.level_o, 2);
    bus.req_i  = 1'b1;
    bus.data_i = 32'h3;
    seen       = 1'b0;
    repeat (20) begin
      step();
      if (bus.ack_o) seen = 1'b1;
    end
    chk("bp_no_ack", seen, 0);
    chk("bp_level", bus.level_o, 2);
    chk("bp_head", bus.data_o, 32'h1);
    bus.ready_i = 1'b1;
    step();
    bus.ready_i = 1'b0;
    chk("bp_pop_level", bus.level_o, 1);
    chk("bp_pop_ack", bus.ack_o, 0);
    chk("bp_pop_head", bus.data_o, 32'h2);
    step();
    chk("bp_cap_ack", bus.ack_o, 1);
    chk("bp_cap_level", bus.level_o, 2);
    chk("bp_cap_head", bus.data_o, 32'h2);
    bus.req_i = 1'b0;
    wait_ack(1'b0, 20, "bp_ack_fall");
    bus.ready_i = 1'b1;
    step();
    bus.ready_i = 1'b0;
    chk("bp_order_head", bus.data_o, 32'h3);
    chk("bp_order_level", bus.level_o, 1);

    // Simultaneous push and pop at level 1
    do_reset();
    send_token(32'hA);
    chk("pp_pre_level", bus.level_o, 1);
    bus.req_i  = 1'b1;
    bus.data_i = 32'hB;
    step();
    step();
    chk("pp_sync_ack", bus.ack_o, 0);
    chk("pp_sync_level", bus.level_o, 1);
    bus.ready_i = 1'b1;
    step();
    bus.ready_i = 1'b0;
    chk("pp_level", bus.level_o, 1);
    chk("pp_head", bus.data_o, 32'hB);
    chk("pp_ack", bus.ack_o, 1);
    bus.req_i = 1'b0;
    wait_ack(1'b0, 20, "pp_ack_fall");

    // Back-to-back stream of 16 tokens
    do_reset();
    sb_en       = 1'b1;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 16; i++) send_token(32'(i));
    drain();
    chk("stream_acks", n_ack, 16);
    chk("stream_rx", n_rx, 16);
    sb_en = 1'b0;

    // Asynchronous reset in WAIT_RTZ with one token stored
    do_reset();
    bus.req_i  = 1'b1;
    bus.data_i = 32'h55;
    wait_ack(1'b1, 20, "mr_ack_rise");
    chk("mr_pre_level", bus.level_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_ack", bus.ack_o, 0);
    chk("mr_valid", bus.valid_o, 0);
    chk("mr_level", bus.level_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk("mr_edge2_ack", bus.ack_o, 0);
    chk("mr_edge2_level", bus.level_o, 0);
    step();
    chk("mr_edge3_ack", bus.ack_o, 1);
    chk("mr_edge3_level", bus.level_o, 1);
    chk("mr_edge3_data", bus.data_o, 32'h55);
    bus.req_i = 1'b0;
    wait_ack(1'b0, 20, "mr_ack_fall");

    // Pointer wrap with alternating ready
    do_reset();
    sb_en      = 1'b1;
    ready_mode = 1;
    for (int i = 0; i < 5; i++) send_token(32'hA0 + 32'(i));
    drain();
    chk("wrap_acks", n_ack, 5);
    chk("wrap_rx", n_rx, 5);
    sb_en = 1'b0;

    // Random tokens, random ready, random gaps
    do_reset();
    sb_en      = 1'b1;
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      send_token($urandom);
      repeat ($urandom_range(0, 3)) step();
    end
    drain();
    chk("rand_acks", n_ack, 40);
    chk("rand_rx", n_rx, 40);
    sb_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
